// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a frame serialiser with
// configurable data width, parity, stop bits and break generation.
module uart_tx_fifo #(
  parameter int CLOCK_DIVISOR_WIDTH = 24,
  parameter int FIFO_DEPTH_LOG2     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           tx,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [7:0]                     dataIn,
  input  logic                           writeData,
  input  logic                           sendBreak,
  input  logic                           clearOverflow,
  output logic                           full,
  output logic                           empty,
  output logic [FIFO_DEPTH_LOG2:0]       level,
  output logic                           busy,
  output logic                           overflow,
  output logic [2:0]                     fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_MARK   = 3'd6
  } state_t;

  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2+1)'(1 << FIFO_DEPTH_LOG2);

  // ---------------------------------------------------------------------
  // FIFO
  // Push handshake: a byte is taken on every rising edge where
  // writeData=1 and full=0. writeData=1 while full=1 drops the byte and
  // raises the sticky overflow flag; the host never waits on a ready.
  // ---------------------------------------------------------------------
  logic [7:0]                 mem [0:(1<<FIFO_DEPTH_LOG2)-1];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push;
  logic                       pop;
  logic [7:0]                 head;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign level = count;
  assign push  = writeData & ~full;
  assign head  = mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dataIn;
  end

  // Pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (writeData && full) overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  state_t                         state;
  state_t                         state_next;
  logic [CLOCK_DIVISOR_WIDTH-1:0] cnt;
  logic [CLOCK_DIVISOR_WIDTH-1:0] div_q;
  logic [2:0]                     last_idx_q;
  logic                           par_en_q;
  logic                           stop2_q;
  logic                           par_q;
  logic [7:0]                     shreg;
  logic [2:0]                     bit_idx;
  logic                           stop_idx;
  logic                           held;
  logic                           bit_done;
  logic                           brk_load;
  logic                           mark_load;
  logic                           decide;
  logic [7:0]                     data_mask;
  logic                           data_xor;
  logic                           par_calc;

  assign bit_done  = (cnt == div_q);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Parity of the head byte, restricted to the bits that will be sent.
  assign data_mask = 8'hFF >> (2'd3 - dataBits);
  assign data_xor  = ^(head & data_mask);

  // Parity bit value for the frame about to be loaded.
  always_comb begin
    par_calc = 1'b0;
    case (parityMode)
      2'b00:   par_calc = 1'b0;
      2'b11:   par_calc = 1'b1;
      2'b10:   par_calc = data_xor;
      default: par_calc = ~data_xor;
    endcase
  end

  // Next-state logic; the idle decision (break first, then data) is shared
  // by IDLE and by the end of the last stop or mark period, which is what
  // lets frames run back-to-back with no idle gap.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    brk_load   = 1'b0;
    mark_load  = 1'b0;
    decide     = 1'b0;
    case (state)
      S_IDLE:   decide = 1'b1;
      S_START:  if (bit_done) state_next = S_DATA;
      S_DATA:   if (bit_done && bit_idx == last_idx_q)
                  state_next = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_next = S_STOP;
      S_STOP:   if (bit_done && stop_idx == stop2_q) decide = 1'b1;
      S_BREAK:  if (!sendBreak && (held || bit_done)) begin
                  state_next = S_MARK;
                  mark_load  = 1'b1;
                end
      S_MARK:   if (bit_done) decide = 1'b1;
      default:  state_next = S_IDLE;
    endcase
    if (decide) begin
      if (sendBreak) begin
        state_next = S_BREAK;
        brk_load   = 1'b1;
      end else if (!empty) begin
        state_next = S_START;
        pop        = 1'b1;
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  // State register plus bit timing and frame datapath; configuration is
  // captured when a frame (or break) starts so mid-frame edits are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      div_q      <= '0;
      last_idx_q <= 3'd7;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      held       <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        div_q      <= clockDivisor;
        last_idx_q <= {1'b0, dataBits} + 3'd4;
        par_en_q   <= hasParity;
        stop2_q    <= extraStopBit;
        par_q      <= par_calc;
        shreg      <= head;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        cnt        <= '0;
      end else if (brk_load) begin
        div_q <= clockDivisor;
        cnt   <= '0;
        held  <= 1'b0;
      end else if (mark_load) begin
        cnt <= '0;
      end else if (state != S_IDLE) begin
        cnt <= bit_done ? '0 : cnt + 1'b1;
        if (bit_done) begin
          if (state == S_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
          if (state == S_STOP)  stop_idx <= 1'b1;
          if (state == S_BREAK) held     <= 1'b1;
        end
      end
    end
  end

  // Line level for the current state; IDLE, STOP and MARK hold the line high.
  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
      S_PARITY: tx = par_q;
      S_BREAK:  tx = 1'b0;
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-exact waveform checks plus a line monitor
// that decodes frames and compares them against an expected-byte queue.
module tb_uart_tx_fifo;

  localparam int CDW  = 24;
  localparam int LOG2 = 4;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            tx;
  logic [1:0]      dataBits;
  logic            hasParity;
  logic [1:0]      parityMode;
  logic            extraStopBit;
  logic [CDW-1:0]  clockDivisor;
  logic [7:0]      dataIn;
  logic            writeData;
  logic            sendBreak;
  logic            clearOverflow;
  logic            full;
  logic            empty;
  logic [LOG2:0]   level;
  logic            busy;
  logic            overflow;
  logic [2:0]      fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLOCK_DIVISOR_WIDTH(CDW), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .tx(tx), .dataBits(dataBits), .hasParity(hasParity),
    .parityMode(parityMode), .extraStopBit(extraStopBit),
    .clockDivisor(clockDivisor), .dataIn(dataIn), .writeData(writeData),
    .sendBreak(sendBreak), .clearOverflow(clearOverflow), .full(full),
    .empty(empty), .level(level), .busy(busy), .overflow(overflow),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames = 0;
  bit         mon_en = 1'b0;
  int         cfg_div;
  int         cfg_bits;
  bit         cfg_par;
  logic [1:0] cfg_mode;
  bit         cfg_stop2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int div, input int bits, input bit par,
                         input logic [1:0] mode, input bit stop2);
    cfg_div = div; cfg_bits = bits; cfg_par = par; cfg_mode = mode; cfg_stop2 = stop2;
    clockDivisor = CDW'(div);
    dataBits     = 2'(bits - 5);
    hasParity    = par;
    parityMode   = mode;
    extraStopBit = stop2;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit track);
    logic [7:0] m;
    m = 8'hFF >> (8 - cfg_bits);
    writeData = 1'b1;
    dataIn    = b;
    if (track) exp_q.push_back(b & m);
    tick();
    writeData = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain_in_budget", (k < budget), 1);
  endtask

  // Push one byte into an idle DUT and check the line cycle by cycle.
  task automatic run_exact(input string tag, input logic [7:0] b,
                           input logic [15:0] bits, input int nbits);
    push_byte(b, 1'b1);
    check({tag, "_level_after_push"}, level, 1);
    check({tag, "_busy_after_push"}, busy, 0);
    check({tag, "_tx_after_push"}, tx, 1);
    tick();
    check({tag, "_level_after_pop"}, level, 0);
    for (int i = 0; i < nbits * (cfg_div + 1); i++) begin
      check({tag, "_tx"}, tx, bits[i / (cfg_div + 1)]);
      check({tag, "_busy"}, busy, 1);
      tick();
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_tx_end"}, tx, 1);
  endtask

  // ---------------- line monitor ----------------
  task automatic rx_frame();
    logic [7:0] data;
    logic       pbit;
    int         d;
    d = cfg_div;
    start_q.push_back(cyc);
    repeat (d / 2) tick();
    check("start_bit", tx, 0);
    data = '0;
    for (int i = 0; i < cfg_bits; i++) begin
      repeat (d + 1) tick();
      data[i] = tx;
    end
    if (cfg_par) begin
      repeat (d + 1) tick();
      case (cfg_mode)
        2'b00:   pbit = 1'b0;
        2'b11:   pbit = 1'b1;
        2'b10:   pbit = ^data;
        default: pbit = ~^data;
      endcase
      check("parity_bit", tx, pbit);
    end
    for (int s = 0; s < 1 + int'(cfg_stop2); s++) begin
      repeat (d + 1) tick();
      check("stop_bit", tx, 1);
    end
    frames++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_frame: got byte=%0h expected no frame", data);
    end else begin
      check("rx_byte", data, exp_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      tick();
      if (mon_en && tx === 1'b0) rx_frame();
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int f0;
    int lows;
    logic [15:0] fbits;

    rst = 1'b1; writeData = 1'b0; dataIn = '0; sendBreak = 1'b0; clearOverflow = 1'b0;
    set_cfg(3, 8, 1'b0, 2'b00, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tx", tx, 1);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    mon_en = 1'b1;

    // 8N1, divisor 3, 0xA5: stop, data msb..lsb, start
    fbits = 16'b000000_1_10100101_0;
    run_exact("t_8n1", 8'hA5, fbits, 10);

    // 7E2, divisor 0, 0x13
    set_cfg(0, 7, 1'b1, 2'b10, 1'b1);
    fbits = 16'b00000_11_1_0010011_0;
    run_exact("t_7e2", 8'h13, fbits, 11);
    // 7O2, divisor 0, 0x13
    set_cfg(0, 7, 1'b1, 2'b01, 1'b1);
    fbits = 16'b00000_11_0_0010011_0;
    run_exact("t_7o2", 8'h13, fbits, 11);
    tick();

    // Back-to-back frames, 8N1 divisor 1
    set_cfg(1, 8, 1'b0, 2'b00, 1'b0);
    start_q.delete();
    push_byte(8'h3C, 1'b1);
    check("b2b_level1", level, 1);
    push_byte(8'hC3, 1'b1);
    push_byte(8'h5A, 1'b1);
    check("b2b_level3", level, 2);
    repeat (19) tick();
    check("b2b_level_frame2", level, 1);
    repeat (20) tick();
    check("b2b_level_frame3", level, 0);
    check("b2b_empty_frame3", empty, 1);
    wait_drain(200);
    check("b2b_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_gap1", start_q[1] - start_q[0], 20);
      check("b2b_gap2", start_q[2] - start_q[1], 20);
    end
    repeat (3) tick();

    // Overflow: one frame in flight, then 17 pushes
    set_cfg(3, 8, 1'b0, 2'b00, 1'b0);
    f0 = frames;
    push_byte(8'h01, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i * 7), 1'b1);
    check("ovf_level16", level, 16);
    check("ovf_full", full, 1);
    check("ovf_pre_flag", overflow, 0);
    push_byte(8'hEE, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_level_kept", level, 16);
    repeat (3) tick();
    check("ovf_sticky", overflow, 1);
    writeData = 1'b1; dataIn = 8'hDD; clearOverflow = 1'b1;
    tick();
    writeData = 1'b0;
    check("ovf_set_wins", overflow, 1);
    tick();
    clearOverflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_drain(2000);
    check("ovf_frame_count", frames - f0, 17);
    repeat (5) tick();

    // Break during a frame, divisor 9
    set_cfg(9, 8, 1'b0, 2'b00, 1'b0);
    push_byte(8'h81, 1'b1);
    push_byte(8'h7E, 1'b1);
    repeat (70) tick();
    sendBreak = 1'b1;
    for (int c = 70; c < 120; c++) begin
      if (c == 95) begin
        check("brk_first_frame_done", exp_q.size(), 1);
        mon_en = 1'b0;
      end
      if (c >= 100) check("brk_tx_low", tx, 0);
      tick();
    end
    sendBreak = 1'b0;
    check("brk_tx_low_release", tx, 0);
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("brk_mark_high", tx, 1);
      tick();
    end
    check("brk_resume_start", tx, 0);
    wait_drain(400);
    repeat (3) tick();

    // Reset mid-DATA with bytes queued
    mon_en = 1'b0;
    exp_q.delete();
    set_cfg(3, 8, 1'b0, 2'b00, 1'b0);
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    check("rstm_level_queued", level, 3);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_tx", tx, 1);
    check("rstm_level", level, 0);
    check("rstm_busy", busy, 0);
    check("rstm_empty", empty, 1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("rstm_no_frames", lows, 0);
    check("rstm_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
